// File: rtl/alu_share_arbiter_if.sv
// Signal bundle tying the ALU share arbiter to its two requesters, the shared ALU and the response sink.
// Signal names are seen from the arbiter: *_i are arbiter inputs, *_o are arbiter outputs.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
);
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [DATA_W-1:0] req0_src1_i;
  logic [DATA_W-1:0] req0_src2_i;
  logic [CTRL_W-1:0] req0_ctrl_i;

  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [DATA_W-1:0] req1_src1_i;
  logic [DATA_W-1:0] req1_src2_i;
  logic [CTRL_W-1:0] req1_ctrl_i;

  logic [DATA_W-1:0] alu_src1_o;
  logic [DATA_W-1:0] alu_src2_o;
  logic [CTRL_W-1:0] alu_ctrl_o;
  logic [DATA_W-1:0] alu_result_i;
  logic              alu_zero_i;

  logic              rsp_valid_o;
  logic              rsp_id_o;
  logic [DATA_W-1:0] rsp_result_o;
  logic              rsp_zero_o;
  logic              rsp_err_o;
  logic              rsp_ready_i;

  // Arbiter side
  modport slave (
    input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    output req0_ready_o, req1_ready_o,
    output alu_src1_o, alu_src2_o, alu_ctrl_o,
    input  alu_result_i, alu_zero_i,
    output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o,
    input  rsp_ready_i
  );

  // Environment side: requesters, shared ALU and response sink
  modport master (
    output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    input  req0_ready_o, req1_ready_o,
    input  alu_src1_o, alu_src2_o, alu_ctrl_o,
    output alu_result_i, alu_zero_i,
    input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, one operation in flight.
// Optional grant counters are enabled by defining ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
`ifdef ALU_ARB_STATS_EN
  ,
  localparam int unsigned CNT_W = 16
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   grant0_cnt_o,
  output logic [CNT_W-1:0]   grant1_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(4'b0111);

  state_t state;
  logic   settle_done;
  logic   last_grant;
  logic   op_id;
  logic   grant_vld;
  logic   grant_id;
  logic   ctrl_ok;

  // Round-robin pick: under contention the requester not granted last time wins
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE && !rst_i) begin
      if (bus.req0_valid_i && bus.req1_valid_i) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant;
      end else if (bus.req0_valid_i) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid_i) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign bus.req0_ready_o = grant_vld & ~grant_id;
  assign bus.req1_ready_o = grant_vld &  grant_id;

  always_comb begin
    ctrl_ok = 1'b0;
    if (bus.alu_ctrl_o inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT}) begin
      ctrl_ok = 1'b1;
    end
  end

  // alu_* double as the operand capture registers; they read zero outside EXEC.
  // EXEC spans two cycles so the ALU settles a full cycle before its result is sampled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      settle_done      <= 1'b0;
      last_grant       <= 1'b1;
      op_id            <= 1'b0;
      bus.alu_src1_o   <= '0;
      bus.alu_src2_o   <= '0;
      bus.alu_ctrl_o   <= '0;
      bus.rsp_valid_o  <= 1'b0;
      bus.rsp_id_o     <= 1'b0;
      bus.rsp_result_o <= '0;
      bus.rsp_zero_o   <= 1'b0;
      bus.rsp_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            bus.alu_src1_o <= grant_id ? bus.req1_src1_i : bus.req0_src1_i;
            bus.alu_src2_o <= grant_id ? bus.req1_src2_i : bus.req0_src2_i;
            bus.alu_ctrl_o <= grant_id ? bus.req1_ctrl_i : bus.req0_ctrl_i;
            op_id          <= grant_id;
            last_grant     <= grant_id;
            settle_done    <= 1'b0;
            state          <= EXEC;
          end
        end
        EXEC: begin
          if (!settle_done) begin
            settle_done <= 1'b1;
          end else begin
            settle_done      <= 1'b0;
            bus.rsp_valid_o  <= 1'b1;
            bus.rsp_id_o     <= op_id;
            bus.rsp_err_o    <= ~ctrl_ok;
            bus.rsp_result_o <= ctrl_ok ? bus.alu_result_i : '0;
            bus.rsp_zero_o   <= ctrl_ok ? bus.alu_zero_i : 1'b1;
            bus.alu_src1_o   <= '0;
            bus.alu_src2_o   <= '0;
            bus.alu_ctrl_o   <= '0;
            state            <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            state           <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Per-requester acceptance counters, free-running wrap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant0_cnt_o <= '0;
      grant1_cnt_o <= '0;
    end else if (grant_vld) begin
      if (grant_id) begin
        grant1_cnt_o <= grant1_cnt_o + CNT_W'(1);
      end else begin
        grant0_cnt_o <= grant0_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: queued requesters, ALU stand-in, behavioural reference.
module tb_alu_share_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
  } op_t;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          acc_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];
  logic glog[$];

  logic last_m = 1'b1;
  int   n_acc0 = 0;
  int   n_acc1 = 0;
  int   acc_count = 0;
  bit   in_resp = 1'b0;
  bit   prev_ready = 1'b0;
  int   rdy_mode = 0;
  int   bp_cnt = 0;

  alu_share_arbiter_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant0_cnt;
  logic [15:0] grant1_cnt;
`endif

  alu_share_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant0_cnt_o (grant0_cnt),
    .grant1_cnt_o (grant1_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference operation: {err, result}
  function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a + b};
      4'b0110: return {1'b0, a - b};
      4'b0111: return {1'b0, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Shared ALU stand-in; illegal codes give junk the arbiter must suppress
  always_comb begin
    logic [32:0] r;
    r = ref_alu(bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o);
    if (r[32]) begin
      bus.alu_result_i = bus.alu_src1_o ^ bus.alu_src2_o ^ 32'hDEAD_BEEF;
      bus.alu_zero_i   = 1'b0;
    end else begin
      bus.alu_result_i = r[31:0];
      bus.alu_zero_i   = (r[31:0] == 32'd0);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic present();
    if (q0.size() > 0) begin
      bus.req0_valid_i = 1'b1;
      bus.req0_src1_i  = q0[0].a;
      bus.req0_src2_i  = q0[0].b;
      bus.req0_ctrl_i  = q0[0].ctrl;
    end else begin
      bus.req0_valid_i = 1'b0;
      bus.req0_src1_i  = $urandom;
      bus.req0_src2_i  = $urandom;
      bus.req0_ctrl_i  = 4'($urandom);
    end
    if (q1.size() > 0) begin
      bus.req1_valid_i = 1'b1;
      bus.req1_src1_i  = q1[0].a;
      bus.req1_src2_i  = q1[0].b;
      bus.req1_ctrl_i  = q1[0].ctrl;
    end else begin
      bus.req1_valid_i = 1'b0;
      bus.req1_src1_i  = $urandom;
      bus.req1_src2_i  = $urandom;
      bus.req1_ctrl_i  = 4'($urandom);
    end
  endtask

  // Requester driver: observes acceptances, predicts the grant, pushes expected responses
  initial begin : driver
    logic v0, v1, r0, r1, pred, acc0, acc1;
    logic [31:0] a, b;
    logic [3:0]  c;
    logic [32:0] ra;
    exp_t e;
    op_t  dump;
    present();
    forever begin
      @(negedge clk);
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (!rst) begin
        v0 = bus.req0_valid_i;
        v1 = bus.req1_valid_i;
        r0 = bus.req0_ready_o;
        r1 = bus.req1_ready_o;
        if (r0 || r1) begin
          pred = (v0 && v1) ? ~last_m : v1;
          check("grant_onehot", {62'd0, r0, r1}, pred ? 64'd1 : 64'd2);
          check("ready_needs_valid", {63'd0, (r0 & ~v0) | (r1 & ~v1)}, 64'd0);
          check("one_in_flight", 64'(sb.size()), 64'd0);
          a  = pred ? bus.req1_src1_i : bus.req0_src1_i;
          b  = pred ? bus.req1_src2_i : bus.req0_src2_i;
          c  = pred ? bus.req1_ctrl_i : bus.req0_ctrl_i;
          ra = ref_alu(c, a, b);
          e.id       = pred;
          e.res      = ra[31:0];
          e.err      = ra[32];
          e.zero     = ra[32] | (ra[31:0] == 32'd0);
          e.acc_edge = cyc + 1;
          sb.push_back(e);
          glog.push_back(r1);
          last_m = pred;
          if (pred) n_acc1++; else n_acc0++;
          acc_count++;
          acc0 = r0;
          acc1 = r1;
        end
      end
      @(posedge clk);
      #1;
      if (acc0 && q0.size() > 0) dump = q0.pop_front();
      if (acc1 && q1.size() > 0) dump = q1.pop_front();
      present();
    end
  end

  // Response sink policy: always ready, random, or hold low five cycles per response
  initial begin : sink
    bus.rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.rsp_ready_i = 1'b1;
        1: bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
        default: begin
          if (bus.rsp_valid_o) begin
            bp_cnt++;
            bus.rsp_ready_i = (bp_cnt > 5);
          end else begin
            bp_cnt = 0;
            bus.rsp_ready_i = 1'b0;
          end
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on each new response and checks it is held until taken
  initial begin : monitor
    exp_t e;
    bit dropped;
    logic        h_id, h_zero, h_err;
    logic [31:0] h_res;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_resp = 1'b0;
        prev_ready = 1'b0;
        continue;
      end
      dropped = 1'b0;
      if (in_resp) begin
        if (prev_ready) begin
          check("rsp_drop", 64'(bus.rsp_valid_o), 64'd0);
          in_resp = 1'b0;
          dropped = 1'b1;
        end else begin
          check("hold_valid", 64'(bus.rsp_valid_o), 64'd1);
          check("hold_id", 64'(bus.rsp_id_o), 64'(h_id));
          check("hold_result", 64'(bus.rsp_result_o), 64'(h_res));
          check("hold_zero", 64'(bus.rsp_zero_o), 64'(h_zero));
          check("hold_err", 64'(bus.rsp_err_o), 64'(h_err));
          check("ready_low_resp", {62'd0, bus.req0_ready_o, bus.req1_ready_o}, 64'd0);
        end
      end
      if (!in_resp && !dropped && bus.rsp_valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(bus.rsp_valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          check("latency_edge", 64'(cyc), 64'(e.acc_edge + 2));
          check("rsp_id", 64'(bus.rsp_id_o), 64'(e.id));
          check("rsp_result", 64'(bus.rsp_result_o), 64'(e.res));
          check("rsp_zero", 64'(bus.rsp_zero_o), 64'(e.zero));
          check("rsp_err", 64'(bus.rsp_err_o), 64'(e.err));
          check("alu_idle_src", 64'(bus.alu_src1_o | bus.alu_src2_o), 64'd0);
          check("alu_idle_ctrl", 64'(bus.alu_ctrl_o), 64'd0);
          check("ready_low_resp", {62'd0, bus.req0_ready_o, bus.req1_ready_o}, 64'd0);
        end
        h_id    = bus.rsp_id_o;
        h_res   = bus.rsp_result_o;
        h_zero  = bus.rsp_zero_o;
        h_err   = bus.rsp_err_o;
        in_resp = 1'b1;
      end
      prev_ready = bus.rsp_ready_i;
    end
  end

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || in_resp) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({name, "_drain"}, 64'(n < budget), 64'd1);
  endtask

  task automatic check_order(input string name, input int cnt);
    check({name, "_count"}, 64'(glog.size()), 64'(cnt));
    for (int i = 0; i < cnt; i++) begin
      if (i < glog.size()) check($sformatf("%s_grant%0d", name, i), 64'(glog[i]), 64'(i % 2));
    end
  endtask

  initial begin : main
    int start;
    int n;
    op_t op;
    logic [3:0] codes[6];
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010;
    codes[3] = 4'b0110; codes[4] = 4'b0111; codes[5] = 4'b0101;

    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_rsp_id", 64'(bus.rsp_id_o), 64'd0);
    check("rst_rsp_result", 64'(bus.rsp_result_o), 64'd0);
    check("rst_rsp_zero", 64'(bus.rsp_zero_o), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err_o), 64'd0);
    check("rst_alu_src1", 64'(bus.alu_src1_o), 64'd0);
    check("rst_alu_src2", 64'(bus.alu_src2_o), 64'd0);
    check("rst_alu_ctrl", 64'(bus.alu_ctrl_o), 64'd0);
    check("rst_ready", {62'd0, bus.req0_ready_o, bus.req1_ready_o}, 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("idle_ready_no_valid", {62'd0, bus.req0_ready_o, bus.req1_ready_o}, 64'd0);

    // Contention straight out of reset: req0 first, then alternating
    glog.delete();
    q0.push_back('{32'd7, 32'd7, 4'b0110});
    q0.push_back('{32'd7, 32'd7, 4'b0110});
    q1.push_back('{32'hFFFF_FFFF, 32'd1, 4'b0111});
    q1.push_back('{32'hFFFF_FFFF, 32'd1, 4'b0111});
    wait_drain(200, "contention");
    check_order("contention", 4);

    // Single add on req0
    q0.push_back('{32'd5, 32'd3, 4'b0010});
    wait_drain(100, "single");

    // Backpressure with a second request waiting behind it
    rdy_mode = 2;
    q0.push_back('{32'h0F0F, 32'h00FF, 4'b0000});
    q1.push_back('{32'h1000, 32'h0001, 4'b0001});
    wait_drain(200, "backpressure");
    rdy_mode = 0;

    // Illegal control code from req1
    q1.push_back('{32'd12, 32'd34, 4'b0101});
    wait_drain(100, "illegal");

    // Asynchronous reset while the operation is executing
    start = acc_count;
    q0.push_back('{32'd9, 32'd4, 4'b0010});
    n = 0;
    while (acc_count == start && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_exec_accept_seen", 64'(acc_count != start), 64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    sb.delete();
    last_m  = 1'b1;
    in_resp = 1'b0;
    n_acc0  = 0;
    n_acc1  = 0;
    #1;
    check("rst_exec_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_exec_alu_src1", 64'(bus.alu_src1_o), 64'd0);
    check("rst_exec_alu_ctrl", 64'(bus.alu_ctrl_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #2;
      check("rst_exec_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    end
    glog.delete();
    q0.push_back('{32'd3, 32'd3, 4'b0000});
    q1.push_back('{32'd1, 32'd2, 4'b0001});
    wait_drain(200, "post_reset");
    check_order("post_reset", 2);

    // Randomised traffic with random response backpressure
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      op.ctrl = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 5)];
      op.a    = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 3));
      op.b    = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) != 0) q1.push_back(op);
      else q0.push_back(op);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_drain(4000, "random");
    rdy_mode = 0;

`ifdef ALU_ARB_STATS_EN
    @(negedge clk);
    check("grant0_cnt", 64'(grant0_cnt), 64'(16'(n_acc0)));
    check("grant1_cnt", 64'(grant1_cnt), 64'(16'(n_acc1)));
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 Parameter: CTRL_W, 4, ALU control code width.
REQ-003 Port: clk_i  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst_i  input  1  reset; asynchronous, active-high.
REQ-005 Ports: reqN_valid_i  input  1  requester N (N=0,1) holds a valid operation.
REQ-006 Ports: reqN_ready_o  output  1  arbiter accepts requester N this cycle.
REQ-007 Ports: reqN_src1_i, reqN_src2_i  input  DATA_W  operands; reqN_ctrl_i  input  CTRL_W  ALU control code.
REQ-008 Ports: alu_src1_o, alu_src2_o  output  DATA_W; alu_ctrl_o  output  CTRL_W  drive the shared combinational ALU.
REQ-009 Ports: alu_result_i  input  DATA_W; alu_zero_i  input  1  shared ALU outputs.
REQ-010 Ports: rsp_valid_o  output  1; rsp_id_o  output  1 (granted requester); rsp_result_o  output  DATA_W; rsp_zero_o  output  1; rsp_err_o  output  1; rsp_ready_i  input  1.

Function
REQ-011 The block SHALL have an FSM with states IDLE, EXEC, RESP.
REQ-012 In IDLE, at most one reqN_ready_o SHALL be high, and only when its reqN_valid_i is high; ready SHALL be low in EXEC and RESP.
REQ-013 Acceptance (valid&ready) SHALL capture src1, src2, ctrl, and requester id into internal registers and move IDLE->EXEC.
REQ-014 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; pointer updates only on acceptance.
REQ-015 In EXEC, alu_src1_o/alu_src2_o/alu_ctrl_o SHALL drive the captured values; at other times they SHALL drive zero.
REQ-016 At end of EXEC, alu_result_i and alu_zero_i SHALL be registered into rsp_result_o/rsp_zero_o; FSM moves EXEC->RESP, rsp_valid_o high.
REQ-017 Latency: acceptance at edge N SHALL give rsp_valid_o high after edge N+2.
REQ-018 Legal ctrl codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT; any other code SHALL give rsp_err_o=1, rsp_result_o=0, rsp_zero_o=1.
REQ-019 rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o SHALL remain stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-020 rsp_valid_o&rsp_ready_i SHALL return RESP->IDLE; new acceptance is possible no earlier than the following cycle (one op in flight at most).
REQ-021 Request inputs changing during EXEC/RESP SHALL not affect the in-flight operation.

Reset
REQ-022 rst_i high SHALL force IDLE immediately, regardless of clock.
REQ-023 Reset values: all ready 0, rsp_valid_o 0, rsp_id_o 0, rsp_result_o 0, rsp_zero_o 0, rsp_err_o 0, alu_* outputs 0, round-robin pointer set so requester 0 wins first contention.
REQ-024 Reset during EXEC or RESP SHALL drop the in-flight operation; no response SHALL be produced for it.

Configuration
REQ-025 Macro ALU_ARB_STATS_EN: when defined, add outputs grant0_cnt_o and grant1_cnt_o (16 bits each), incremented on each acceptance of that requester, wrapping 16'hFFFF->0, reset to 0.
REQ-026 When ALU_ARB_STATS_EN is undefined, the counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Single op: req0 valid, src1=5, src2=3, ctrl=0010, rsp_ready=1 -> rsp_valid two cycles after accept, rsp_id=0, result=8, zero=0, err=0.
REQ-028 Contention: both valid continuously, req0 SUB 7-7, req1 SLT -1<1 -> grant order 0,1,0,1; req0 result 0 zero=1; req1 result 1 zero=0.
REQ-029 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> outputs held stable, both readies low; rsp_ready=1 -> IDLE next cycle.
REQ-030 Illegal ctrl 0101 from req1 -> rsp_err=1, result=0, zero=1, rsp_id=1.
REQ-031 Assert rst_i asynchronously in EXEC -> rsp_valid stays 0, FSM IDLE, next contention grants req0.
REQ-032 With ALU_ARB_STATS_EN: 65537 req0 accepts -> grant0_cnt_o=1, grant1_cnt_o=0.
